ahb_bus_arbiter: RTL
====================

// Module: ahb_bus_arbiter
// PURPOSE
//  Shares one AHB-Lite address/data bus between NUM_MASTERS ahb masters (one master instance per MIPS requester).
//  Round-robin grant with per-tenure beat limit; parks the bus on DEFAULT_MASTER when nobody requests.
//  HMASTER steers the top-level address/control/write-data muxes; HGRANT feeds each master's FSM.
// PARAMETERS
//  NUM_MASTERS     4   number of requesting masters (2..8)
//  MAX_BEATS       16  accepted beats per tenure before forced re-arbitration (1..255)
//  DEFAULT_MASTER  0   park master index when no HBUSREQ is asserted
// PORTS
//  HCLK       in   1            bus clock
//  HRESETn    in   1            asynchronous active-low reset
//  HBUSREQ    in   NUM_MASTERS  bus request, one bit per master, level
//  HLOCK      in   NUM_MASTERS  locked-sequence request (only with AHB_ARB_LOCK_EN; else tie 0, ignored)
//  HTRANS     in   2            transfer type of current bus owner (IDLE=00 BUSY=01 NONSEQ=10 SEQ=11)
//  HREADY     in   1            bus ready from slave mux
//  HGRANT     out  NUM_MASTERS  one-hot grant, registered
//  HMASTER    out  $clog2(NUM_MASTERS)  index of master owning the current address phase
//  HMASTLOCK  out  1            current address phase is locked
// BEHAVIOUR
//  Reset: HGRANT=1<<DEFAULT_MASTER, HMASTER=DEFAULT_MASTER, HMASTLOCK=0, state=PARK, beat_cnt=0, last=DEFAULT_MASTER.
//  States: PARK (no request, default master granted, must drive IDLE); OWN (requester granted); LOCK (macro only).
//  Accepted beat: HREADY=1 and HTRANS in {NONSEQ,SEQ}; beat_cnt increments, saturates at MAX_BEATS.
//  Re-arbitration point (rp): HREADY=1 and (HTRANS==IDLE or beat_cnt==MAX_BEATS) and state!=LOCK.
//  At rp: winner = first set HBUSREQ bit searching last+1, last+2 ... wrapping mod NUM_MASTERS, last itself checked last.
//   winner found -> HGRANT<=onehot(winner), last<=winner, beat_cnt<=0, state<=OWN.
//   none -> HGRANT<=onehot(DEFAULT_MASTER), state<=PARK.
//  HGRANT changes only at rp; between rp it holds even if owner drops HBUSREQ (owner must drive IDLE -> rp next ready).
//  HMASTER<=index(HGRANT) on every HREADY=1 edge (handover one cycle after grant); held while HREADY=0.
//  Latency: request seen at rp -> HGRANT next edge -> HMASTER next HREADY edge (min 2 cycles to address phase).
//  Beat limit: at MAX_BEATS, grant moves to next requester even mid-burst; if the owner is the only requester it is re-granted, beat_cnt=0.
//  HREADY=0: no state, grant or HMASTER change; beat_cnt holds.
//  Simultaneous requests: resolved purely by round-robin order; no master wins twice while another waits.
//  Reset mid-transfer: async return to reset values; current transfer abandoned.
// CONFIGURATION
//  AHB_ARB_LOCK_EN defined: winner with HLOCK=1 at grant -> state LOCK; HMASTLOCK<=1 with HMASTER update;
//   LOCK ignores beat limit; exits at first HREADY=1 with HTRANS==IDLE and HLOCK[owner]=0, then normal rp.
//  Not defined: HLOCK ignored, LOCK state absent, HMASTLOCK constant 0.
// STRUCTURE
//  Shared package ahb_pkg: HTRANS codes (HT_IDLE/HT_BUSY/HT_NONSEQ/HT_SEQ), arbiter state encoding (ARB_PARK/ARB_OWN/ARB_LOCK).
//  One sub-module: ahb_rr_pick (combinational rotate-priority-encoder: req vector + last -> winner index + valid).
//  Arbiter body: state register, beat counter, grant/HMASTER registers.
// TESTING
//  1 Reset, no requests -> HGRANT=0001, HMASTER=0, HMASTLOCK=0; HTRANS=IDLE, HREADY=1 for 10 cycles -> unchanged.
//  2 HBUSREQ=0110 at rp, last=0 -> HGRANT=0010 next edge, HMASTER=1 next HREADY edge; owner IDLE -> HGRANT=0100.
//  3 Master 1 sole requester, SEQ beats, MAX_BEATS=16, HREADY=1 -> re-granted after beat 16, beat_cnt back to 0.
//  4 Masters 1,3 request, 1 bursting -> at beat 16 HGRANT=1000; hold HREADY=0 for 3 cycles at rp -> no change until HREADY=1.
//  5 AHB_ARB_LOCK_EN: master 2 HLOCK=1, 40 beats with master 0 requesting -> HGRANT=0100, HMASTLOCK=1 throughout; release -> master 0.
//  6 Assert HRESETn=0 mid-burst while HREADY=0 -> outputs at reset values immediately, no HCLK edge required.

Source files
------------

// File: rtl/ahb_pkg.sv
// ahb_pkg
//   Shared AHB-Lite definitions for the bus arbiter slice.
//   - htrans_e    : HTRANS transfer-type codes
//   - arb_state_e : arbiter FSM state encoding
//   - BEAT_W      : width of the per-tenure beat counter (covers MAX_BEATS up to 255)
package ahb_pkg;

    typedef enum logic [1:0] {
        HT_IDLE   = 2'b00,
        HT_BUSY   = 2'b01,
        HT_NONSEQ = 2'b10,
        HT_SEQ    = 2'b11
    } htrans_e;

    typedef enum logic [1:0] {
        ARB_PARK = 2'b00,
        ARB_OWN  = 2'b01,
        ARB_LOCK = 2'b10
    } arb_state_e;

    localparam int BEAT_W = 8;

endpackage

// File: rtl/ahb_rr_pick.sv
// ahb_rr_pick
//   Combinational rotate-priority encoder for round-robin arbitration.
//   The search starts at last_i+1 and wraps modulo NUM_MASTERS; last_i itself
//   is examined last, so a previous winner only wins again when nobody else asks.
// Ports
//   req_i    [NUM_MASTERS-1:0]  request vector
//   last_i   [IW-1:0]           index of the previous winner
//   winner_o [IW-1:0]           index of the selected requester
//   valid_o                     at least one request bit is set
module ahb_rr_pick #(
    parameter int NUM_MASTERS = 4,
    parameter int IW          = $clog2(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req_i,
    input  logic [IW-1:0]          last_i,
    output logic [IW-1:0]          winner_o,
    output logic                   valid_o
);

    // Walk the search order backwards so the last hit written is the
    // earliest position in round-robin order.
    always_comb begin
        int idx;
        idx      = 0;
        winner_o = '0;
        valid_o  = 1'b0;
        for (int i = NUM_MASTERS; i >= 1; i--) begin
            idx = int'(last_i) + i;
            if (idx >= NUM_MASTERS) begin
                idx = idx - NUM_MASTERS;
            end
            if (req_i[idx]) begin
                winner_o = IW'(idx);
                valid_o  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ahb_bus_arbiter.sv
// ahb_bus_arbiter
//   Round-robin AHB-Lite bus arbiter with a per-tenure beat limit. The bus is
//   parked on DEFAULT_MASTER when nobody requests. HGRANT only moves at a
//   re-arbitration point; HMASTER follows HGRANT on the next HREADY edge.
//   Optional locked transfers are enabled by defining AHB_ARB_LOCK_EN; without
//   it HLOCK is ignored, the LOCK state is unreachable and HMASTLOCK is 0.
// Ports
//   HCLK, HRESETn          clock, asynchronous active-low reset
//   HBUSREQ[N-1:0]         level bus requests
//   HLOCK[N-1:0]           locked-sequence requests (AHB_ARB_LOCK_EN only)
//   HTRANS[1:0]            transfer type of the current bus owner
//   HREADY                 bus ready from slave mux
//   HGRANT[N-1:0]          registered one-hot grant
//   HMASTER[IW-1:0]        owner of the current address phase
//   HMASTLOCK              current address phase is locked
//   dbg_state_o[1:0]       arbiter FSM state (arb_state_e encoding)
//   dbg_beat_cnt_o[7:0]    accepted beats in the current tenure
module ahb_bus_arbiter
    import ahb_pkg::*;
#(
    parameter int NUM_MASTERS    = 4,
    parameter int MAX_BEATS      = 16,
    parameter int DEFAULT_MASTER = 0,
    parameter int IW             = $clog2(NUM_MASTERS)
) (
    input  logic                   HCLK,
    input  logic                   HRESETn,
    input  logic [NUM_MASTERS-1:0] HBUSREQ,
    input  logic [NUM_MASTERS-1:0] HLOCK,
    input  logic [1:0]             HTRANS,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] HGRANT,
    output logic [IW-1:0]          HMASTER,
    output logic                   HMASTLOCK,
    output logic [1:0]             dbg_state_o,
    output logic [BEAT_W-1:0]      dbg_beat_cnt_o
);

    localparam logic [NUM_MASTERS-1:0] DEF_GRANT =
        {{(NUM_MASTERS-1){1'b0}}, 1'b1} << DEFAULT_MASTER;
    localparam logic [IW-1:0]     DEF_IDX = IW'(DEFAULT_MASTER);
    localparam logic [BEAT_W-1:0] MAX_CNT = BEAT_W'(MAX_BEATS);

    arb_state_e             state_q, state_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [IW-1:0]          last_q, last_d;
    logic [IW-1:0]          hmaster_q, hmaster_d;
    logic [BEAT_W-1:0]      cnt_q, cnt_d;
    logic                   mlock_q, mlock_d;

    logic [IW-1:0] win_idx;
    logic          win_vld;
    logic [IW-1:0] grant_idx;
    logic          beat_acc;
    logic          is_idle;
    logic          rp;

    ahb_rr_pick #(
        .NUM_MASTERS (NUM_MASTERS),
        .IW          (IW)
    ) u_pick (
        .req_i    (HBUSREQ),
        .last_i   (last_q),
        .winner_o (win_idx),
        .valid_o  (win_vld)
    );

    // One-hot grant back to an index for HMASTER.
    always_comb begin
        grant_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q[i]) begin
                grant_idx = IW'(i);
            end
        end
    end

    // NONSEQ and SEQ both have HTRANS[1] set.
    assign beat_acc = HREADY && HTRANS[1];
    assign is_idle  = (HTRANS == HT_IDLE);

`ifdef AHB_ARB_LOCK_EN
    // A locked tenure ignores the beat limit and only ends once the owner
    // goes idle with its lock request withdrawn.
    logic lock_exit;
    assign lock_exit = (state_q == ARB_LOCK) && is_idle && !HLOCK[last_q];
    assign rp = HREADY && (((state_q != ARB_LOCK) && (is_idle || (cnt_q == MAX_CNT)))
                           || lock_exit);
`else
    logic unused_hlock;
    assign unused_hlock = ^HLOCK;
    assign rp = HREADY && (is_idle || (cnt_q == MAX_CNT));
`endif

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        last_d    = last_q;
        hmaster_d = hmaster_q;
        cnt_d     = cnt_q;
        mlock_d   = mlock_q;

        if (beat_acc && (cnt_q != MAX_CNT)) begin
            cnt_d = cnt_q + 1'b1;
        end

        // Address-phase ownership follows the grant one ready cycle later.
        if (HREADY) begin
            hmaster_d = grant_idx;
`ifdef AHB_ARB_LOCK_EN
            mlock_d   = (state_q == ARB_LOCK);
`endif
        end

        // A new tenure starts its count from zero, even if a beat was
        // accepted on the same edge.
        if (rp) begin
            cnt_d = '0;
            if (win_vld) begin
                grant_d          = '0;
                grant_d[win_idx] = 1'b1;
                last_d           = win_idx;
                state_d          = ARB_OWN;
`ifdef AHB_ARB_LOCK_EN
                if (HLOCK[win_idx]) begin
                    state_d = ARB_LOCK;
                end
`endif
            end else begin
                grant_d = DEF_GRANT;
                state_d = ARB_PARK;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= ARB_PARK;
            grant_q   <= DEF_GRANT;
            last_q    <= DEF_IDX;
            hmaster_q <= DEF_IDX;
            cnt_q     <= '0;
            mlock_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            hmaster_q <= hmaster_d;
            cnt_q     <= cnt_d;
            mlock_q   <= mlock_d;
        end
    end

    assign HGRANT         = grant_q;
    assign HMASTER        = hmaster_q;
    assign HMASTLOCK      = mlock_q;
    assign dbg_state_o    = state_q;
    assign dbg_beat_cnt_o = cnt_q;

endmodule
